icache: RTL

Direct-mapped, read-only instruction cache serving the fetch stage's request/response interface. Each cycle it accepts a PC from fetch, returns the 32-bit instruction one cycle later on a hit, and on a miss stalls the response while it refills a full line from the memory port. It sits between fetch and the memory interconnect, and owns line invalidation for `fence.i`.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_data_ram.sv | 36 +++
 rtl/icache.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// The ICACHE_PERF_EN macro (see icache.sv) adds hit/miss performance counters.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL
  } icache_state_e;

  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int calc_word_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Everything above the byte offset, word select and index is tag.
  function automatic int calc_tag_w(input int num_lines, input int line_words);
    return 30 - $clog2(num_lines) - $clog2(line_words);
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] addr, input int line_words);
    logic [31:0] mask;
    mask = 32'(line_words * 4) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data array: one write port for refill beats, one registered read port for hits.
module icache_data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic          we_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register doubles as the response data, so it holds its value between hits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= 32'd0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-line refill and fence.i flush.
// Define ICACHE_PERF_EN to add hit_cnt_o / miss_cnt_o lookup counters.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ic_req_valid_i,
  input  logic [31:0] ic_req_addr_i,
  output logic        ic_rsp_valid_o,
  output logic [31:0] ic_rsp_data_o,
  input  logic        flush_i,
  output logic        mem_req_valid_o,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  input  logic [31:0] mem_rsp_data_i
);

  localparam int IDX_W  = calc_idx_w(NUM_LINES);
  localparam int WORD_W = calc_word_w(LINE_WORDS);
  localparam int TAG_W  = calc_tag_w(NUM_LINES, LINE_WORDS);

  icache_state_e state_q, state_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              rsp_valid_q;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [WORD_W-1:0] req_word;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic              tag_hit, lookup_hit, lookup_miss, ram_we, install;
  logic              unused_offset;

  assign req_word      = ic_req_addr_i[2 +: WORD_W];
  assign req_idx       = ic_req_addr_i[2 + WORD_W +: IDX_W];
  assign req_tag       = ic_req_addr_i[31 -: TAG_W];
  assign miss_idx      = miss_addr_q[2 + WORD_W +: IDX_W];
  assign miss_tag      = miss_addr_q[31 -: TAG_W];
  assign tag_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_offset = ^ic_req_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    lookup_hit   = 1'b0;
    lookup_miss  = 1'b0;
    ram_we       = 1'b0;
    install      = 1'b0;
    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        // A flush cycle performs no lookup at all.
        if (ic_req_valid_i && !flush_i) begin
          if (tag_hit) begin
            lookup_hit = 1'b1;
          end else begin
            lookup_miss = 1'b1;
            miss_addr_d = line_addr(ic_req_addr_i, LINE_WORDS);
            state_d     = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_req_ready_i) begin
          state_d = REFILL;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_rsp_valid_i) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            install = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      miss_addr_q  <= 32'd0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      rsp_valid_q  <= lookup_hit;
    end
  end

  // A flush seen at any point of the refill keeps the installed line invalid.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q[gi] <= 1'b0;
      end else if (flush_i) begin
        valid_q[gi] <= 1'b0;
      end else if (install && !flush_pend_q && (miss_idx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (install) begin
      tag_q[miss_idx] <= miss_tag;
    end
  end

  icache_data_ram #(
    .DEPTH(NUM_LINES * LINE_WORDS),
    .AW   (IDX_W + WORD_W)
  ) u_data_ram (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rd_en_i  (lookup_hit),
    .rd_addr_i({req_idx, req_word}),
    .rd_data_o(ic_rsp_data_o),
    .we_i     (ram_we),
    .wr_addr_i({miss_idx, cnt_q}),
    .wr_data_i(mem_rsp_data_i)
  );

  assign ic_rsp_valid_o  = rsp_valid_q;
  assign mem_req_valid_o = (state_q == MISS_REQ);
  assign mem_req_addr_o  = miss_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
